target_sum_tracker: RTL

Parametrised successor to the single-target comparator block. It latches a target value on an explicit load and accepts a stream of value pairs under a valid strobe. It reports whether a pair sums to the target, whether either value equals the target, or whether the current first value plus a recently seen second value hits the target, using a circular history of depth DEPTH. It sits between the stimulus/number source and the result/display logic.

---
 rtl/target_sum_tracker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/target_sum_tracker.sv
// Target-sum tracker: latches a target on load, then checks incoming value pairs for
// equality, pair-sum or first-plus-recent-second hits against a circular history.
//
//   state    | meaning
//   ST_IDLE  | no target loaded, pairs ignored
//   ST_ARMED | target loaded, pairs accepted and checked
//   ST_FOUND | a hit was reported, result held until next load
module target_sum_tracker #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_load,
    input  logic [WIDTH-1:0]         i_target_in,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_first_num,
    input  logic [WIDTH-1:0]         i_second_num,
    output logic [1:0]               o_result,
    output logic [$clog2(DEPTH)-1:0] o_hit_index,
    output logic [CW-1:0]            o_match_count,
    output logic                     o_armed,
    output logic                     o_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FOUND = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_target;
    logic [WIDTH-1:0]    r_hist [DEPTH];
    logic [DEPTH-1:0]    r_hist_vld;
    logic [AW-1:0]       r_wptr;
    logic [1:0]          r_result;
    logic [AW-1:0]       r_hit_index;
    logic [CW-1:0]       r_match_count;
    logic                r_armed;
    logic                r_done;

    logic [WIDTH:0]      w_sum;
    logic                w_eq;
    logic                w_sum_hit;
    logic                w_cross;
    logic [AW-1:0]       w_cross_age;

    // Sums are taken one bit wider than the operands so a carry never aliases the target.
    always_comb begin
        logic [AW-1:0] v_idx;
        v_idx       = '0;
        w_sum       = {1'b0, i_first_num} + {1'b0, i_second_num};
        w_eq        = (i_first_num == r_target) || (i_second_num == r_target);
        w_sum_hit   = (w_sum == {1'b0, r_target});
        w_cross     = 1'b0;
        w_cross_age = '0;
        // Oldest first, so the youngest hit is the one left standing.
        for (int a = DEPTH - 1; a >= 0; a--) begin
            v_idx = r_wptr - AW'(a) - AW'(1);
            if (r_hist_vld[v_idx] &&
                (({1'b0, i_first_num} + {1'b0, r_hist[v_idx]}) == {1'b0, r_target})) begin
                w_cross     = 1'b1;
                w_cross_age = AW'(a);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_target      <= '0;
            r_hist_vld    <= '0;
            r_wptr        <= '0;
            r_result      <= 2'b00;
            r_hit_index   <= '0;
            r_match_count <= '0;
            r_armed       <= 1'b0;
            r_done        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (i_load) begin
            r_state       <= ST_ARMED;
            r_target      <= i_target_in;
            r_hist_vld    <= '0;
            r_wptr        <= '0;
            r_result      <= 2'b00;
            r_hit_index   <= '0;
            r_match_count <= '0;
            r_armed       <= 1'b1;
            r_done        <= 1'b0;
        end else if (r_state == ST_ARMED && i_valid) begin
            r_hist[r_wptr]     <= i_second_num;
            r_hist_vld[r_wptr] <= 1'b1;
            r_wptr             <= r_wptr + AW'(1);
            if (r_match_count != {CW{1'b1}}) begin
                r_match_count <= r_match_count + CW'(1);
            end
            r_hit_index <= '0;
            if (w_eq || w_sum_hit || w_cross) begin
                r_state <= ST_FOUND;
                r_armed <= 1'b0;
                r_done  <= 1'b1;
            end
            if (w_eq) begin
                r_result <= 2'b11;
            end else if (w_sum_hit) begin
                r_result <= 2'b01;
            end else if (w_cross) begin
                r_result    <= 2'b10;
                r_hit_index <= w_cross_age;
            end
        end
    end

    assign o_result      = r_result;
    assign o_hit_index   = r_hit_index;
    assign o_match_count = r_match_count;
    assign o_armed       = r_armed;
    assign o_done        = r_done;

endmodule
